// File: rtl/accum_ctrl_pkg.sv
// ============================================================================
// Module : accum_ctrl_pkg
// Brief  : Shared states, op codes and requester indices for accum_share_ctrl.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package accum_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int REQ_A = 0;
  localparam int REQ_B = 1;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ============================================================================
// Module : rr_arbiter2
// Brief  : Two-way round-robin arbiter; the pointer names the favoured side.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter2
  import accum_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  input  logic [1:0] i_last_gnt,
  output logic [1:0] o_gnt
);

  // r_ptr = 0 favours A, 1 favours B
  logic r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (i_advance) begin
      r_ptr <= i_last_gnt[REQ_A];
    end
  end

  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = r_ptr ? 2'b10 : 2'b01;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/accum_share_ctrl.sv
// ============================================================================
// Module : accum_share_ctrl
// Brief  : One add/sub accumulator shared by two requesters via req/ack.
//          Define ACCUM_SATURATE_EN to clamp on overflow instead of wrapping.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module accum_share_ctrl
  import accum_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req,
  input  logic [1:0]   add_n,
  input  logic [N-1:0] operand_a,
  input  logic [N-1:0] operand_b,
  input  logic         clr,
  output logic [1:0]   gnt,
  output logic [1:0]   ack,
  output logic [N-1:0] acc,
  output logic         ovf,
  output logic         busy
);

  state_t       r_state;
  state_t       w_next;
  logic [1:0]   r_gnt;
  logic         r_op;
  logic [N-1:0] r_operand;
  logic [N-1:0] r_acc;
  logic         r_ovf;

  logic [1:0]   w_arb_gnt;
  logic [N:0]   w_res;
  logic         w_ovf;
  logic [N-1:0] w_acc_nxt;

  rr_arbiter2 u_arb (
    .clk        (clk),
    .rst        (reset),
    .i_req      (req),
    .i_advance  (r_state == ST_RESP),
    .i_last_gnt (r_gnt),
    .o_gnt      (w_arb_gnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (!clr && (req != 2'b00)) w_next = ST_EXEC;
      ST_EXEC: w_next = ST_RESP;
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Sign-extended N+1 bit result: top two bits disagree exactly on signed overflow
  always_comb begin
    if (r_op == OP_SUB) w_res = {r_acc[N-1], r_acc} - {r_operand[N-1], r_operand};
    else                w_res = {r_acc[N-1], r_acc} + {r_operand[N-1], r_operand};
    w_ovf = w_res[N] ^ w_res[N-1];
`ifdef ACCUM_SATURATE_EN
    if (w_ovf) w_acc_nxt = w_res[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    else       w_acc_nxt = w_res[N-1:0];
`else
    w_acc_nxt = w_res[N-1:0];
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gnt     <= 2'b00;
      r_op      <= OP_ADD;
      r_operand <= '0;
      r_acc     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (clr) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
          end else if (w_arb_gnt != 2'b00) begin
            r_gnt     <= w_arb_gnt;
            r_op      <= w_arb_gnt[REQ_B] ? add_n[REQ_B] : add_n[REQ_A];
            r_operand <= w_arb_gnt[REQ_B] ? operand_b : operand_a;
          end
        end
        ST_EXEC: begin
          r_acc <= w_acc_nxt;
          r_ovf <= w_ovf;
        end
        ST_RESP: r_gnt <= 2'b00;
        default: r_gnt <= 2'b00;
      endcase
    end
  end

  assign gnt  = r_gnt;
  assign ack  = (r_state == ST_RESP) ? r_gnt : 2'b00;
  assign acc  = r_acc;
  assign ovf  = r_ovf;
  assign busy = (r_state != ST_IDLE);

endmodule

`default_nettype wire
